key_pulse_array: RTL and testbench

Parametrised N-channel front end for asynchronous push-button inputs. Each channel provides:
- synchronisation into `clk`;
- counter-based debouncing;
- single-cycle press and release pulses;
- optional per-channel auto-repeat while the key is held.

It sits between raw board keys and the control FSMs, which consume only one-cycle pulses. It is the next generation of the two-key enter/exit conditioner.

---
 rtl/key_pulse_array_if.sv | 32 +++
 rtl/key_pulse_array.sv | 114 +++++++++++
 tb/tb_key_pulse_array.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_pulse_array_if.sv
// Key conditioner bus: raw key levels and repeat enables in, debounced
// level and one-cycle press/pulse/release strobes out, one bit per channel.
interface key_pulse_array_if #(
   parameter int N = 2
);
   logic [N-1:0] key_i;
   logic [N-1:0] repeat_en_i;
   logic [N-1:0] level_o;
   logic [N-1:0] press_o;
   logic [N-1:0] pulse_o;
   logic [N-1:0] release_o;

   // Driver side: board keys / control logic
   modport master (
      output key_i,
      output repeat_en_i,
      input  level_o,
      input  press_o,
      input  pulse_o,
      input  release_o
   );

   // Conditioner side
   modport slave (
      input  key_i,
      input  repeat_en_i,
      output level_o,
      output press_o,
      output pulse_o,
      output release_o
   );
endinterface

// File: rtl/key_pulse_array.sv
// key_pulse_array: N independent push-button channels. Each channel
// synchronises its raw key, debounces it with a mismatch counter, and emits
// one-cycle press/release strobes plus an optional auto-repeat pulse train.
module key_pulse_array #(
   parameter int N            = 2,
   parameter int SYNC_STAGES  = 2,
   parameter int DEBOUNCE     = 4,
   parameter int REPEAT_DELAY = 8,
   parameter int REPEAT_RATE  = 3
) (
   input logic              clk,
   input logic              Reset,
   key_pulse_array_if.slave bus
);

   localparam int CW   = $clog2(DEBOUNCE + 1);
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW   = $clog2(RMAX + 1);

   localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE - 1);
   localparam logic [RW-1:0] DELAY_LIM = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RATE_LIM  = RW'(REPEAT_RATE - 1);

   for (genvar i = 0; i < N; i++) begin : g_chan
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   sync_s;
      logic [CW-1:0]          cnt_q, cnt_d;
      logic                   level_q, level_d;
      logic                   press_q, press_d;
      logic                   release_q, release_d;
      logic                   pulse_q, pulse_d;
      logic [RW-1:0]          rcnt_q, rcnt_d;
      logic [RW-1:0]          rep_lim;
      logic                   phase_q, phase_d;
      logic                   accept;
      logic                   rep_fire;

      assign sync_s = sync_q[SYNC_STAGES-1];

      // Shift the raw key through the synchroniser chain
      always_ff @(posedge clk or posedge Reset) begin
         if (Reset) sync_q <= '0;
         else       sync_q <= {sync_q[SYNC_STAGES-2:0], bus.key_i[i]};
      end

      // Debounce: accept a new level after DEBOUNCE consecutive mismatches
      always_comb begin
         cnt_d     = cnt_q;
         level_d   = level_q;
         press_d   = 1'b0;
         release_d = 1'b0;
         accept    = 1'b0;
         if (sync_s == level_q) begin
            cnt_d = '0;
         end else if (cnt_q == CNT_MAX) begin
            accept    = 1'b1;
            level_d   = sync_s;
            cnt_d     = '0;
            press_d   = sync_s;
            release_d = ~sync_s;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      assign rep_lim = phase_q ? RATE_LIM : DELAY_LIM;

      // Auto-repeat: delay phase after press, then fixed rate; any accepted
      // change, released level or disabled repeat restarts the delay phase
      always_comb begin
         rcnt_d   = rcnt_q;
         phase_d  = phase_q;
         rep_fire = 1'b0;
         if (accept || !level_q || !bus.repeat_en_i[i]) begin
            rcnt_d  = '0;
            phase_d = 1'b0;
         end else if (rcnt_q == rep_lim) begin
            rep_fire = 1'b1;
            rcnt_d   = '0;
            phase_d  = 1'b1;
         end else begin
            rcnt_d = rcnt_q + 1'b1;
         end
         pulse_d = press_d | rep_fire;
      end

      // Channel state and registered outputs
      always_ff @(posedge clk or posedge Reset) begin
         if (Reset) begin
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            pulse_q   <= 1'b0;
            rcnt_q    <= '0;
            phase_q   <= 1'b0;
         end else begin
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            pulse_q   <= pulse_d;
            rcnt_q    <= rcnt_d;
            phase_q   <= phase_d;
         end
      end

      assign bus.level_o[i]   = level_q;
      assign bus.press_o[i]   = press_q;
      assign bus.pulse_o[i]   = pulse_q;
      assign bus.release_o[i] = release_q;
   end

endmodule

// File: tb/tb_key_pulse_array.sv
// Bench for key_pulse_array: a default instance and a fast-debounce /
// continuous-repeat instance share stimulus and are checked against a
// time-window reference model and against directed timing expectations.
module tb_key_pulse_array;

   localparam int P_SYNC [2] = '{2, 3};
   localparam int P_DB   [2] = '{4, 1};
   localparam int P_RD   [2] = '{8, 8};
   localparam int P_RR   [2] = '{3, 1};

   logic       clk   = 1'b0;
   logic       Reset = 1'b1;
   logic [1:0] key   = '0;
   logic [1:0] ren   = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   key_pulse_array_if #(.N(2)) ifa ();
   key_pulse_array_if #(.N(2)) ifb ();

   assign ifa.key_i       = key;
   assign ifa.repeat_en_i = ren;
   assign ifb.key_i       = key;
   assign ifb.repeat_en_i = ren;

   key_pulse_array #(.N(2), .SYNC_STAGES(2), .DEBOUNCE(4), .REPEAT_DELAY(8), .REPEAT_RATE(3))
      dut_a (.clk(clk), .Reset(Reset), .bus(ifa));
   key_pulse_array #(.N(2), .SYNC_STAGES(3), .DEBOUNCE(1), .REPEAT_DELAY(8), .REPEAT_RATE(1))
      dut_b (.clk(clk), .Reset(Reset), .bus(ifb));

   // Reference model: edge-indexed history since reset. A change is accepted
   // when the last DEBOUNCE synchronised samples all disagree with the level
   // and no change was accepted within that window; repeats fall at fixed
   // offsets from the last edge that cleared the repeat timer.
   bit [1:0] m_lv [2];
   bit [1:0] m_pr [2];
   bit [1:0] m_pu [2];
   bit [1:0] m_rl [2];
   bit       kb [2][2][64];
   bit       sb [2][2][64];
   int       e [2];
   int       last_acc [2][2];
   int       rstart [2][2];

   always @(posedge clk or posedge Reset) begin
      bit s, acc, fire;
      int dd;
      if (Reset) begin
         for (int d = 0; d < 2; d++) begin
            e[d] = 0; m_lv[d] = '0; m_pr[d] = '0; m_pu[d] = '0; m_rl[d] = '0;
            for (int c = 0; c < 2; c++) begin
               last_acc[d][c] = 0; rstart[d][c] = 0;
               for (int j = 0; j < 64; j++) begin kb[d][c][j] = 1'b0; sb[d][c][j] = 1'b0; end
            end
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            e[d] = e[d] + 1;
            for (int c = 0; c < 2; c++) begin
               s = (e[d] > P_SYNC[d]) ? kb[d][c][(e[d] - P_SYNC[d]) % 64] : 1'b0;
               kb[d][c][e[d] % 64] = key[c];
               sb[d][c][e[d] % 64] = s;
               acc = (e[d] - last_acc[d][c] >= P_DB[d]);
               if (acc)
                  for (int j = 0; j < P_DB[d]; j++)
                     if (sb[d][c][(e[d] - j) % 64] == m_lv[d][c]) acc = 1'b0;
               fire = 1'b0;
               if (acc || !m_lv[d][c] || !ren[c]) begin
                  rstart[d][c] = e[d];
               end else begin
                  dd   = e[d] - rstart[d][c];
                  fire = (dd == P_RD[d]) || (dd > P_RD[d] && (dd - P_RD[d]) % P_RR[d] == 0);
               end
               if (acc) begin
                  m_lv[d][c]     = ~m_lv[d][c];
                  last_acc[d][c] = e[d];
               end
               m_pr[d][c] = acc & m_lv[d][c];
               m_rl[d][c] = acc & ~m_lv[d][c];
               m_pu[d][c] = m_pr[d][c] | fire;
            end
         end
      end
   end

   wire [15:0] dut_vec = {ifb.level_o, ifb.press_o, ifb.pulse_o, ifb.release_o,
                          ifa.level_o, ifa.press_o, ifa.pulse_o, ifa.release_o};
   wire [15:0] mdl_vec = {m_lv[1], m_pr[1], m_pu[1], m_rl[1],
                          m_lv[0], m_pr[0], m_pu[0], m_rl[0]};

   task automatic idle(input int n);
      key = '0;
      ren = '0;
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      key = '0; ren = '0; Reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (dut_vec !== 16'h0) begin
         errors++; $display("FAIL reset_state: got %h want 0000", dut_vec);
      end
      Reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (dut_vec !== mdl_vec) begin
            errors++; $display("FAIL reset_idle: cyc %0d got %h want %h", i, dut_vec, mdl_vec);
         end
      end
   endtask

   task automatic test_bounce;
      key = 2'b01;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         checks++;
         if (dut_vec !== mdl_vec) begin
            errors++; $display("FAIL bounce_model: cyc %0d got %h want %h", i, dut_vec, mdl_vec);
         end
         checks++;
         if ({ifa.level_o[0], ifa.press_o[0], ifa.pulse_o[0]} !== 3'b000) begin
            errors++;
            $display("FAIL bounce_reject: cyc %0d lvl/press/pulse=%b want 000", i,
                     {ifa.level_o[0], ifa.press_o[0], ifa.pulse_o[0]});
         end
         key[0] = (i + 1 < 3) || (i + 1 >= 4 && i + 1 < 7);
      end
   endtask

   task automatic test_press_hold;
      key = 2'b01; ren = 2'b00;
      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         checks++;
         if (dut_vec !== mdl_vec) begin
            errors++; $display("FAIL hold_model: cyc %0d got %h want %h", i, dut_vec, mdl_vec);
         end
         checks++;
         if ({ifa.level_o[0], ifa.press_o[0], ifa.pulse_o[0], ifa.release_o[0]} !==
             {(i >= 5 && i < 17), (i == 5), (i == 5), (i == 17)}) begin
            errors++;
            $display("FAIL hold_timing: cyc %0d lvl/press/pulse/rel=%b", i,
                     {ifa.level_o[0], ifa.press_o[0], ifa.pulse_o[0], ifa.release_o[0]});
         end
         checks++;
         if ({ifb.press_o[0], ifb.release_o[0]} !== {(i == 3), (i == 15)}) begin
            errors++;
            $display("FAIL hold_fast: cyc %0d press/rel=%b", i, {ifb.press_o[0], ifb.release_o[0]});
         end
         if (i == 11) key[0] = 1'b0;
      end
   endtask

   task automatic test_auto_repeat;
      key = 2'b10; ren = 2'b10;
      for (int i = 0; i < 41; i++) begin
         @(negedge clk);
         checks++;
         if (dut_vec !== mdl_vec) begin
            errors++; $display("FAIL repeat_model: cyc %0d got %h want %h", i, dut_vec, mdl_vec);
         end
         checks++;
         if ({ifa.press_o[1], ifa.pulse_o[1]} !==
             {(i == 5), (i == 5) || (i >= 13 && i < 36 && (i - 13) % 3 == 0)}) begin
            errors++;
            $display("FAIL repeat_cadence: cyc %0d press/pulse=%b", i, {ifa.press_o[1], ifa.pulse_o[1]});
         end
         if (i == 30) key[1] = 1'b0;
      end
   endtask

   task automatic test_channels;
      key = 2'b11; ren = 2'b01;
      for (int i = 0; i < 31; i++) begin
         @(negedge clk);
         checks++;
         if (dut_vec !== mdl_vec) begin
            errors++; $display("FAIL chan_model: cyc %0d got %h want %h", i, dut_vec, mdl_vec);
         end
         checks++;
         if ({ifa.press_o, ifa.pulse_o, ifa.release_o[1]} !==
             {(i == 5), (i == 5), (i == 5), (i == 5) || (i >= 13 && (i - 13) % 3 == 0), (i == 20)}) begin
            errors++;
            $display("FAIL chan_indep: cyc %0d press=%b pulse=%b rel1=%b", i,
                     ifa.press_o, ifa.pulse_o, ifa.release_o[1]);
         end
         if (i == 14) key[1] = 1'b0;
      end
   endtask

   task automatic test_reset_mid;
      key = 2'b01; ren = 2'b00;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (dut_vec !== mdl_vec) begin
            errors++; $display("FAIL rstmid_model: cyc %0d got %h want %h", i, dut_vec, mdl_vec);
         end
      end
      checks++;
      if (ifa.level_o[0] !== 1'b1) begin
         errors++; $display("FAIL rstmid_pre: level0=%b want 1", ifa.level_o[0]);
      end
      #2 Reset = 1'b1;
      #1;
      checks++;
      if (dut_vec !== 16'h0) begin
         errors++; $display("FAIL rstmid_async: got %h want 0000", dut_vec);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (dut_vec !== 16'h0) begin
         errors++; $display("FAIL rstmid_held: got %h want 0000", dut_vec);
      end
      Reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (dut_vec !== mdl_vec) begin
            errors++; $display("FAIL rstmid_model2: cyc %0d got %h want %h", i, dut_vec, mdl_vec);
         end
         checks++;
         if ({ifa.press_o[0], ifa.release_o[0], ifb.press_o[0]} !== {(i == 5), 1'b0, (i == 3)}) begin
            errors++;
            $display("FAIL rstmid_repress: cyc %0d a_press/a_rel/b_press=%b", i,
                     {ifa.press_o[0], ifa.release_o[0], ifb.press_o[0]});
         end
      end
   endtask

   task automatic test_param_sweep;
      key = 2'b01; ren = 2'b01;
      for (int i = 0; i < 28; i++) begin
         @(negedge clk);
         checks++;
         if (dut_vec !== mdl_vec) begin
            errors++; $display("FAIL sweep_model: cyc %0d got %h want %h", i, dut_vec, mdl_vec);
         end
         checks++;
         if ({ifb.press_o[0], ifb.pulse_o[0], ifb.release_o[0]} !==
             {(i == 3), (i == 3) || (i >= 11 && i < 23), (i == 23)}) begin
            errors++;
            $display("FAIL sweep_timing: cyc %0d press/pulse/rel=%b", i,
                     {ifb.press_o[0], ifb.pulse_o[0], ifb.release_o[0]});
         end
         if (i == 19) key[0] = 1'b0;
      end
   endtask

   task automatic test_random;
      int lim;
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         checks++;
         if (dut_vec !== mdl_vec) begin
            errors++; $display("FAIL random_model: cyc %0d got %h want %h", i, dut_vec, mdl_vec);
         end
         lim = ((i / 200) % 2 == 1) ? 29 : 3;
         if ($urandom_range(0, lim) == 0) key[0] = ~key[0];
         if ($urandom_range(0, lim) == 0) key[1] = ~key[1];
         if ($urandom_range(0, 39) == 0) ren = 2'($urandom_range(0, 3));
      end
   endtask

   initial begin
      test_reset;
      idle(4);
      test_bounce;
      idle(12);
      test_press_hold;
      idle(12);
      test_auto_repeat;
      idle(12);
      test_channels;
      idle(12);
      test_reset_mid;
      idle(12);
      test_param_sweep;
      idle(12);
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
